// File: rtl/mul_seq_unit_pkg.sv
// Shared ALU package: alu_control encodings used by the decoder and the
// execute-stage units, plus the multiply sequencer state type.
package mul_seq_unit_pkg;

  localparam logic [4:0] ALU_MUL    = 5'b01111;
  localparam logic [4:0] ALU_MULH   = 5'b10000;
  localparam logic [4:0] ALU_MULHSU = 5'b10001;
  localparam logic [4:0] ALU_MULHU  = 5'b10010;
  localparam logic [4:0] ALU_MULW   = 5'b10111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } mul_seq_state_t;

  // True for the op codes the multiply sequencer actually computes.
  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == ALU_MUL)    || (op == ALU_MULH)  || (op == ALU_MULHSU) ||
           (op == ALU_MULHU)  || (op == ALU_MULW);
  endfunction

endpackage

// File: rtl/mul_seq_step.sv
// One shift-add step of the iterative multiplier.
//   acc_i   : running 2*XLEN accumulator
//   mcand_i : multiplicand, already aligned to the current digit position
//   digit_i : next BITS_PER_CYCLE multiplier bits
//   acc_o   : acc_i + mcand_i * digit_i
module mul_seq_step #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic [2*XLEN-1:0]         acc_i,
  input  logic [2*XLEN-1:0]         mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] digit_i,
  output logic [2*XLEN-1:0]         acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit_i[i]) begin
        acc_o = acc_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Multi-cycle M-extension multiply sequencer (MUL/MULH/MULHSU/MULHU/MULW).
//   clk_i, arstn_i          : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o : request handshake (ready only in IDLE)
//   alu_control_i           : op code, src_a_i/src_b_i : operands
//   flush_i                 : abort current operation, block acceptance
//   resp_valid_o/resp_ready_i, result_o : response handshake and result
//   busy_o                  : unit is not idle
module mul_seq_unit
  import mul_seq_unit_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [4:0]      alu_control_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int unsigned N     = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  mul_seq_state_t state_q, state_d;

  logic [4:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;      // raw rs2, then the right-shifting multiplier
  logic [2*XLEN-1:0] mcand_q;  // left-shifting multiplicand
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   result_sel;

  assign accept = (state_q == IDLE) && req_valid_i && !flush_i;

  // Operand conditioning for PREP: signed operands become magnitudes and
  // the product sign is restored in FIX.
  always_comb begin
    sign_a = ((op_q == ALU_MULH) || (op_q == ALU_MULHSU)) && a_q[XLEN-1];
    sign_b = (op_q == ALU_MULH) && b_q[XLEN-1];
    mag_a  = sign_a ? -a_q : a_q;
    mag_b  = sign_b ? -b_q : b_q;
    if (op_q == ALU_MULW) begin
      mag_a = XLEN'(a_q[31:0]);
      mag_b = XLEN'(b_q[31:0]);
    end
  end

  mul_seq_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc_i  (acc_q),
    .mcand_i(mcand_q),
    .digit_i(b_q[BITS_PER_CYCLE-1:0]),
    .acc_o  (acc_step)
  );

  always_comb begin
    prod       = neg_q ? -acc_q : acc_q;
    result_sel = '0;
    case (op_q)
      ALU_MUL:                           result_sel = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU:   result_sel = prod[2*XLEN-1:XLEN];
      ALU_MULW:                          result_sel = XLEN'($signed(prod[31:0]));
      default:                           result_sel = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = PREP;
      PREP: state_d = is_mul_op(op_q) ? CALC : DONE;
      CALC: if (cnt_q == CNT_W'(N - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush beats every other transition, including a DONE handshake.
    if (flush_i && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q <= alu_control_i;
            a_q  <= src_a_i;
            b_q  <= src_b_i;
          end
        end
        PREP: begin
          mcand_q <= {{XLEN{1'b0}}, mag_a};
          b_q     <= mag_b;
          neg_q   <= sign_a ^ sign_b;
          acc_q   <= '0;
          cnt_q   <= '0;
          if (!is_mul_op(op_q) && !flush_i) begin
            result_q <= '0;
          end
        end
        CALC: begin
          acc_q   <= acc_step;
          mcand_q <= mcand_q << BITS_PER_CYCLE;
          b_q     <= b_q >> BITS_PER_CYCLE;
          cnt_q   <= cnt_q + 1'b1;
        end
        FIX: begin
          if (!flush_i) begin
            result_q <= result_sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == DONE);
  assign busy_o       = (state_q != IDLE);
  assign result_o     = result_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
module tb_mul_seq_unit;
  import mul_seq_unit_pkg::*;

  localparam int LAT = 64 / 2 + 3;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  alu_control_i;
  logic [63:0] src_a_i;
  logic [63:0] src_b_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] result_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb_q[$];

  mul_seq_unit #(
    .XLEN          (64),
    .BITS_PER_CYCLE(2)
  ) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .alu_control_i(alu_control_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .flush_i      (flush_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .result_o     (result_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model using plain 128-bit modular arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    p = '0;
    w = '0;
    case (op)
      ALU_MUL:    begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
      ALU_MULH:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      ALU_MULHSU: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
      ALU_MULHU:  begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
      ALU_MULW:   begin w = {32'b0, a[31:0]} * {32'b0, b[31:0]}; return {{32{w[31]}}, w[31:0]}; end
      default:    return 64'b0;
    endcase
  endfunction

  // Drive one request, wait (bounded) for the response, check latency,
  // req_ready_o during the operation and the result; leaves the unit in DONE.
  task automatic issue(input string tag, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    int   lat;
    logic ready_seen;
    logic [63:0] e;
    lat        = 0;
    ready_seen = 1'b0;
    check1({tag, "_ready_before"}, req_ready_o, 1'b1);
    alu_control_i = op;
    src_a_i       = a;
    src_b_i       = b;
    req_valid_i   = 1'b1;
    sb_q.push_back(exp);
    tick();
    lat         = 1;
    req_valid_i = 1'b0;
    src_a_i     = {$urandom(), $urandom()};
    src_b_i     = {$urandom(), $urandom()};
    alu_control_i = 5'(($urandom()));
    while (!resp_valid_o && lat < 100) begin
      if (req_ready_o) ready_seen = 1'b1;
      tick();
      lat++;
    end
    checki({tag, "_latency"}, lat, exp_lat);
    check1({tag, "_ready_low_busy"}, ready_seen, 1'b0);
    e = sb_q.pop_front();
    if (resp_valid_o) check64({tag, "_result"}, result_o, e);
  endtask

  task automatic handshake(input string tag);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    check1({tag, "_valid_dropped"}, resp_valid_o, 1'b0);
    check1({tag, "_ready_back"}, req_ready_o, 1'b1);
  endtask

  initial begin : stim
    logic [4:0]  ops[5];
    logic [63:0] ra, rb;
    logic        seen;
    ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_MULW};

    arstn_i       = 1'b0;
    req_valid_i   = 1'b0;
    alu_control_i = '0;
    src_a_i       = '0;
    src_b_i       = '0;
    flush_i       = 1'b0;
    resp_ready_i  = 1'b0;
    tick();
    tick();
    check1("rst_ready", req_ready_o, 1'b1);
    check1("rst_valid", resp_valid_o, 1'b0);
    check1("rst_busy", busy_o, 1'b0);
    check64("rst_result", result_o, 64'h0);
    arstn_i = 1'b1;
    tick();

    // Main function: directed vectors
    issue("mul", ALU_MUL, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, LAT);
    handshake("mul");
    issue("mulh", ALU_MULH, '1, '1, 64'h0, LAT);
    handshake("mulh");
    issue("mulhu", ALU_MULHU, '1, '1, 64'hFFFFFFFFFFFFFFFE, LAT);
    handshake("mulhu");
    issue("mulhsu", ALU_MULHSU, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, LAT);
    handshake("mulhsu");
    issue("mulw_a", ALU_MULW, 64'h10000, 64'h8000, 64'hFFFFFFFF80000000, LAT);
    handshake("mulw_a");
    issue("mulw_b", ALU_MULW, 64'hDEADBEEF00000003, 64'd5, 64'hF, LAT);
    handshake("mulw_b");
    issue("mulw_c", ALU_MULW, 64'h80000000, 64'd2, 64'h0, LAT);
    handshake("mulw_c");
    issue("mulh_min", ALU_MULH, 64'h8000000000000000, 64'h8000000000000000,
          64'h4000000000000000, LAT);
    handshake("mulh_min");

    // Randomised operands against the model
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      issue("rand", ops[i % 5], ra, rb, model(ops[i % 5], ra, rb), LAT);
      handshake("rand");
    end

    // Backpressure in DONE
    issue("bp", ALU_MULHU, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321,
          model(ALU_MULHU, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321), LAT);
    for (int i = 0; i < 5; i++) begin
      tick();
      check64("bp_result_hold", result_o,
              model(ALU_MULHU, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321));
      check1("bp_valid_hold", resp_valid_o, 1'b1);
      check1("bp_ready_low", req_ready_o, 1'b0);
    end
    handshake("bp");
    issue("bp_next", ALU_MUL, 64'd3, 64'd5, 64'd15, LAT);
    handshake("bp_next");

    // Flush on the 10th CALC cycle
    alu_control_i = ALU_MUL;
    src_a_i       = 64'd9;
    src_b_i       = 64'd9;
    req_valid_i   = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check1("flush_busy_before", busy_o, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check1("flush_ready", req_ready_o, 1'b1);
    check1("flush_valid", resp_valid_o, 1'b0);
    check1("flush_busy", busy_o, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_o) seen = 1'b1;
      tick();
    end
    check1("flush_no_resp", seen, 1'b0);

    // Flush in IDLE blocks acceptance
    alu_control_i = ALU_MUL;
    req_valid_i   = 1'b1;
    flush_i       = 1'b1;
    tick();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    check1("flush_idle_busy", busy_o, 1'b0);
    check1("flush_idle_ready", req_ready_o, 1'b1);

    // Flush and resp_ready together in DONE
    issue("flush_done", ALU_MUL, 64'd6, 64'd7, 64'd42, LAT);
    flush_i      = 1'b1;
    resp_ready_i = 1'b1;
    tick();
    flush_i      = 1'b0;
    resp_ready_i = 1'b0;
    check1("flush_done_valid", resp_valid_o, 1'b0);
    check1("flush_done_ready", req_ready_o, 1'b1);

    // Unsupported op: result cleared, two cycles after acceptance
    issue("unsup", 5'b00000, 64'd6, 64'd7, 64'h0, 2);
    handshake("unsup");

    // Asynchronous reset mid-CALC, with a non-zero result pending
    issue("pre_rst", ALU_MUL, 64'd11, 64'd13, 64'd143, LAT);
    handshake("pre_rst");
    alu_control_i = ALU_MULHU;
    src_a_i       = '1;
    src_b_i       = '1;
    req_valid_i   = 1'b1;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    #2;
    arstn_i = 1'b0;
    #1;
    check1("arst_ready", req_ready_o, 1'b1);
    check1("arst_valid", resp_valid_o, 1'b0);
    check1("arst_busy", busy_o, 1'b0);
    check64("arst_result", result_o, 64'h0);
    tick();
    arstn_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid_o || busy_o) seen = 1'b1;
      tick();
    end
    check1("arst_no_resp", seen, 1'b0);
    issue("post_rst", ALU_MULW, 64'hFFFFFFFF_FFFFFFFF, 64'd1, 64'hFFFFFFFFFFFFFFFF, LAT);
    handshake("post_rst");

    checki("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
